// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// One access in flight at a time; load/store wins unless fetch has starved too long.
module mem_port_arbiter #(
  parameter int XLEN       = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_if_req,
  input  logic [XLEN-1:0] i_if_addr,
  output logic            o_if_gnt,
  output logic            o_if_stall,
  output logic            o_if_rvalid,
  output logic [XLEN-1:0] o_if_rdata,
  input  logic            i_ls_req,
  input  logic            i_ls_we,
  input  logic [XLEN-1:0] i_ls_addr,
  input  logic [XLEN-1:0] i_ls_wdata,
  output logic            o_ls_gnt,
  output logic            o_ls_stall,
  output logic            o_ls_rvalid,
  output logic [XLEN-1:0] o_ls_rdata,
  output logic            o_mem_en,
  output logic            o_mem_we,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_wdata,
  input  logic [XLEN-1:0] i_mem_rdata
);

  localparam int LW = $clog2(MEM_LAT + 2);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY_IF, S_BUSY_LS} state_t;

  state_t            r_state, w_next;
  logic [LW-1:0]     r_lat_cnt;
  logic [SW-1:0]     r_starve_cnt;
  logic              r_drop;
  logic              r_mem_en, r_mem_we;
  logic [XLEN-1:0]   r_mem_addr, r_mem_wdata;
  logic              r_if_rvalid, r_ls_rvalid;
  logic [XLEN-1:0]   r_if_rdata, r_ls_rdata;
  logic              w_if_gnt, w_ls_gnt, w_if_pick, w_done;

  always_comb begin
    w_next    = r_state;
    w_if_gnt  = 1'b0;
    w_ls_gnt  = 1'b0;
    w_if_pick = i_if_req & ~i_flush &
                (~i_ls_req | (r_starve_cnt == SW'(STARVE_MAX)));
    w_done    = (r_state != S_IDLE) && (r_lat_cnt == '0);
    case (r_state)
      S_IDLE: begin
        if (!i_rst) begin
          if (w_if_pick) begin
            w_if_gnt = 1'b1;
            w_next   = S_BUSY_IF;
          end else if (i_ls_req) begin
            w_ls_gnt = 1'b1;
            w_next   = S_BUSY_LS;
          end
        end
      end
      S_BUSY_IF, S_BUSY_LS: if (r_lat_cnt == '0) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_lat_cnt    <= '0;
      r_starve_cnt <= '0;
      r_drop       <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_if_rvalid  <= 1'b0;
      r_ls_rvalid  <= 1'b0;
      r_if_rdata   <= '0;
      r_ls_rdata   <= '0;
    end else begin
      r_state  <= w_next;
      r_mem_en <= w_if_gnt | w_ls_gnt;
      if (w_if_gnt | w_ls_gnt) begin
        r_mem_addr  <= w_ls_gnt ? i_ls_addr : i_if_addr;
        r_mem_we    <= w_ls_gnt & i_ls_we;
        r_mem_wdata <= w_ls_gnt ? i_ls_wdata : '0;
        r_lat_cnt   <= LW'(MEM_LAT);
      end else if (r_state != S_IDLE && r_lat_cnt != '0) begin
        r_lat_cnt <= r_lat_cnt - LW'(1);
      end

      r_if_rvalid <= 1'b0;
      r_ls_rvalid <= 1'b0;
      if (w_done && r_state == S_BUSY_IF) begin
        // Dropped fetches still refresh rdata; only the valid pulse is killed.
        r_if_rdata  <= i_mem_rdata;
        r_if_rvalid <= ~r_drop & ~i_flush;
      end
      if (w_done && r_state == S_BUSY_LS) begin
        r_ls_rvalid <= 1'b1;
        if (!r_mem_we) r_ls_rdata <= i_mem_rdata;
      end

      if (w_done)
        r_drop <= 1'b0;
      else if (r_state == S_BUSY_IF && i_flush)
        r_drop <= 1'b1;

      if (w_ls_gnt && i_if_req) begin
        if (r_starve_cnt != SW'(STARVE_MAX)) r_starve_cnt <= r_starve_cnt + SW'(1);
      end else if (w_if_gnt) begin
        r_starve_cnt <= '0;
      end else if (r_state == S_IDLE && !i_if_req) begin
        r_starve_cnt <= '0;
      end
    end
  end

  assign o_if_gnt    = w_if_gnt;
  assign o_ls_gnt    = w_ls_gnt;
  assign o_if_stall  = i_if_req & ~w_if_gnt;
  assign o_ls_stall  = i_ls_req & ~w_ls_gnt;
  // A flush landing in the valid cycle itself still cancels the fetch.
  assign o_if_rvalid = r_if_rvalid & ~i_flush;
  assign o_ls_rvalid = r_ls_rvalid;
  assign o_if_rdata  = r_if_rdata;
  assign o_ls_rdata  = r_ls_rdata;
  assign o_mem_en    = r_mem_en;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic, checked
// every cycle against a transaction-level model with its own memory image.
module tb_mem_port_arbiter;
  localparam int XLEN = 32, MEM_LAT = 2, STARVE_MAX = 4;
  localparam int HN = 4096;

  logic clk = 1'b0;
  logic i_rst, i_flush, i_if_req, i_ls_req, i_ls_we;
  logic [31:0] i_if_addr, i_ls_addr, i_ls_wdata, i_mem_rdata;
  logic o_if_gnt, o_if_stall, o_if_rvalid, o_ls_gnt, o_ls_stall, o_ls_rvalid;
  logic o_mem_en, o_mem_we;
  logic [31:0] o_if_rdata, o_ls_rdata, o_mem_addr, o_mem_wdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.XLEN(XLEN), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_flush(i_flush),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(o_if_gnt),
    .o_if_stall(o_if_stall), .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_ls_req(i_ls_req), .i_ls_we(i_ls_we), .i_ls_addr(i_ls_addr),
    .i_ls_wdata(i_ls_wdata), .o_ls_gnt(o_ls_gnt), .o_ls_stall(o_ls_stall),
    .o_ls_rvalid(o_ls_rvalid), .o_ls_rdata(o_ls_rdata),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata));

  function automatic logic [31:0] init_val(int i);
    if (i == 0) return 32'h0050_0093;
    if (i == 64) return 32'hDEAD_BEEF;
    return 32'h5A5A_0000 ^ (32'(i) * 32'h0101_0101);
  endfunction

  // Memory: data is valid only exactly MEM_LAT cycles after the o_mem_en cycle.
  logic [31:0] mem [256];
  bit          memv [256];
  int          age = 0;
  logic [31:0] mad = 0;
  always @(posedge clk) begin
    if (o_mem_en) begin
      age <= 1;
      mad <= o_mem_addr;
      if (o_mem_we) begin
        mem[o_mem_addr[9:2]]  <= o_mem_wdata;
        memv[o_mem_addr[9:2]] <= 1'b1;
      end
    end else if (age != 0 && age < 1000) age <= age + 1;
  end
  assign i_mem_rdata = (age == MEM_LAT) ?
    (memv[mad[9:2]] ? mem[mad[9:2]] : init_val(int'(mad[9:2]))) :
    (32'hBAD0_0000 ^ 32'(age));

  // Reference model: one transaction record plus absolute cycle stamps.
  int cyc = 0, total = 0, bad = 0;
  logic [31:0] refmem [256];
  bit          refv [256];
  bit m_act, m_is_if, m_we, m_drop;
  int m_tg, m_done, m_starve;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_ls_rdata;
  bit e_if_gnt, e_ls_gnt, e_mem_en, e_if_rv, e_ls_rv;

  logic [31:0] h_ifg[HN], h_lsg[HN], h_ifst[HN], h_men[HN], h_mwe[HN], h_mwd[HN];
  logic [31:0] h_mad[HN], h_ifrv[HN], h_lsrv[HN], h_ifrd[HN], h_lsrd[HN], h_stv[HN];

  function automatic logic [31:0] rd(logic [31:0] a);
    return refv[a[9:2]] ? refmem[a[9:2]] : init_val(int'(a[9:2]));
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_eval();
    bit idle, pick_if;
    idle     = !m_act || cyc == m_done;
    pick_if  = i_if_req && !i_flush && (!i_ls_req || m_starve == STARVE_MAX);
    e_if_gnt = idle && !i_rst && pick_if;
    e_ls_gnt = idle && !i_rst && i_ls_req && !pick_if;
    e_mem_en = m_act && cyc == m_tg + 1;
    e_if_rv  = m_act && cyc == m_done && m_is_if && !m_drop && !i_flush;
    e_ls_rv  = m_act && cyc == m_done && !m_is_if;
  endtask

  task automatic model_commit();
    bit idle;
    idle = !m_act || cyc == m_done;
    if (i_rst) begin
      m_act = 0; m_starve = 0; m_drop = 0; m_if_rdata = 0; m_ls_rdata = 0;
      return;
    end
    if (m_act && cyc == m_done - 1) begin
      if (m_is_if) m_if_rdata = rd(m_addr);
      else if (!m_we) m_ls_rdata = rd(m_addr);
    end
    if (m_act && m_is_if && i_flush && cyc > m_tg && cyc < m_done) m_drop = 1;
    if (m_act && cyc == m_done) begin m_act = 0; m_drop = 0; end
    if (e_ls_gnt && i_if_req) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
    else if (e_if_gnt) m_starve = 0;
    else if (idle && !i_if_req) m_starve = 0;
    if (e_if_gnt || e_ls_gnt) begin
      m_act = 1; m_tg = cyc; m_done = cyc + MEM_LAT + 2; m_is_if = e_if_gnt;
      m_we = e_ls_gnt && i_ls_we; m_drop = 0;
      m_addr  = e_ls_gnt ? i_ls_addr : i_if_addr;
      m_wdata = e_ls_gnt ? i_ls_wdata : 32'h0;
      if (m_we) begin refmem[m_addr[9:2]] = m_wdata; refv[m_addr[9:2]] = 1; end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_eval();
    chk("if_gnt", o_if_gnt, e_if_gnt);
    chk("ls_gnt", o_ls_gnt, e_ls_gnt);
    chk("if_stall", o_if_stall, i_if_req & ~e_if_gnt);
    chk("ls_stall", o_ls_stall, i_ls_req & ~e_ls_gnt);
    chk("mem_en", o_mem_en, e_mem_en);
    if (e_mem_en) begin
      chk("mem_we", o_mem_we, m_we);
      chk("mem_addr", o_mem_addr, m_addr);
      if (m_we) chk("mem_wdata", o_mem_wdata, m_wdata);
    end
    chk("if_rvalid", o_if_rvalid, e_if_rv);
    chk("ls_rvalid", o_ls_rvalid, e_ls_rv);
    chk("if_rdata", o_if_rdata, m_if_rdata);
    chk("ls_rdata", o_ls_rdata, m_ls_rdata);
    if (cyc < HN) begin
      h_ifg[cyc] = 32'(o_if_gnt);   h_lsg[cyc] = 32'(o_ls_gnt);
      h_ifst[cyc] = 32'(o_if_stall); h_men[cyc] = 32'(o_mem_en);
      h_mwe[cyc] = 32'(o_mem_we);   h_mwd[cyc] = o_mem_wdata;
      h_mad[cyc] = o_mem_addr;      h_ifrv[cyc] = 32'(o_if_rvalid);
      h_lsrv[cyc] = 32'(o_ls_rvalid); h_ifrd[cyc] = o_if_rdata;
      h_lsrd[cyc] = o_ls_rdata;     h_stv[cyc] = 32'(dut.r_starve_cnt);
    end
    @(posedge clk);
    model_commit();
    #1;
    cyc++;
  endtask

  initial begin
    int t, u;
    i_rst = 1; i_flush = 0; i_if_req = 0; i_ls_req = 0; i_ls_we = 0;
    i_if_addr = 0; i_ls_addr = 0; i_ls_wdata = 0;
    m_act = 0; m_starve = 0; m_drop = 0; m_if_rdata = 0; m_ls_rdata = 0;
    m_tg = 0; m_done = 0; m_is_if = 0; m_we = 0; m_addr = 0; m_wdata = 0;
    @(posedge clk); #1;

    // Reset held with both requests up: no grants, registered state cleared.
    i_if_req = 1; i_ls_req = 1;
    tick();
    chk("rst_if_gnt", h_ifg[0], 0);
    chk("rst_ls_gnt", h_lsg[0], 0);
    chk("rst_mem_en", h_men[0], 0);
    chk("rst_ifrd", h_ifrd[0], 0);
    i_rst = 0; i_if_req = 0; i_ls_req = 0;
    repeat (3) tick();

    // Single fetch.
    t = cyc; i_if_req = 1; i_if_addr = 32'h0;
    tick(); i_if_req = 0;
    repeat (5) tick();
    chk("t1_gnt", h_ifg[t], 1);
    chk("t1_stall", h_ifst[t], 0);
    chk("t1_mem_en", h_men[t+1], 1);
    chk("t1_mem_we", h_mwe[t+1], 0);
    chk("t1_rvalid", h_ifrv[t+4], 1);
    chk("t1_rdata", h_ifrd[t+4], 32'h0050_0093);

    // Simultaneous fetch and load.
    t = cyc; i_if_req = 1; i_if_addr = 32'h0;
    i_ls_req = 1; i_ls_we = 0; i_ls_addr = 32'h100;
    tick(); i_ls_req = 0;
    repeat (4) tick();
    i_if_req = 0;
    repeat (5) tick();
    chk("t2_ls_gnt", h_lsg[t], 1);
    for (int k = 0; k < 4; k++) chk("t2_if_stall", h_ifst[t+k], 1);
    chk("t2_ls_rvalid", h_lsrv[t+4], 1);
    chk("t2_ls_rdata", h_lsrd[t+4], 32'hDEAD_BEEF);
    chk("t2_if_gnt", h_ifg[t+4], 1);
    chk("t2_if_rvalid", h_ifrv[t+8], 1);

    // Starvation limit: stores contend with a held fetch.
    t = cyc; i_if_req = 1; i_if_addr = 32'h0;
    i_ls_req = 1; i_ls_we = 1; i_ls_addr = 32'h300; i_ls_wdata = 32'hCAFE_0001;
    repeat (21) tick();
    i_if_req = 0; i_ls_req = 0;
    repeat (6) tick();
    for (int k = 0; k < 4; k++) chk("t3_ls_order", h_lsg[t+4*k], 1);
    chk("t3_if_turn", h_ifg[t+16], 1);
    chk("t3_ls_after", h_lsg[t+20], 1);
    chk("t3_starve_pre", h_stv[t+16], 4);
    chk("t3_starve_post", h_stv[t+17], 0);

    // Store leaves ls_rdata at the previous load value.
    t = cyc; i_ls_req = 1; i_ls_we = 1; i_ls_addr = 32'h200; i_ls_wdata = 32'h1234_5678;
    tick(); i_ls_req = 0; i_ls_we = 0;
    repeat (5) tick();
    chk("t4_mem_we", h_mwe[t+1], 1);
    chk("t4_mem_wdata", h_mwd[t+1], 32'h1234_5678);
    chk("t4_rvalid", h_lsrv[t+4], 1);
    chk("t4_rdata_kept", h_lsrd[t+4], 32'hDEAD_BEEF);

    // Flush during a fetch, then a flush coincident with a request in idle.
    t = cyc; i_if_req = 1; i_if_addr = 32'h0;
    tick(); i_if_req = 0;
    tick();
    i_flush = 1; tick(); i_flush = 0;
    tick();
    i_if_req = 1; i_if_addr = 32'h4;
    tick(); i_if_req = 0;
    repeat (5) tick();
    chk("t5_no_rvalid", h_ifrv[t+4], 0);
    chk("t5_regrant", h_ifg[t+4], 1);
    chk("t5_next_rvalid", h_ifrv[t+8], 1);
    u = cyc; i_if_req = 1; i_flush = 1;
    tick(); i_flush = 0;
    tick(); i_if_req = 0;
    repeat (5) tick();
    chk("t5_flush_blocks", h_ifg[u], 0);
    chk("t5_flush_stall", h_ifst[u], 1);
    chk("t5_after_flush", h_ifg[u+1], 1);

    // Reset mid-transaction.
    t = cyc; i_ls_req = 1; i_ls_we = 0; i_ls_addr = 32'h100;
    tick(); i_ls_req = 0;
    tick();
    i_rst = 1; tick(); i_rst = 0;
    i_ls_req = 1; i_ls_addr = 32'h40;
    tick(); i_ls_req = 0;
    repeat (5) tick();
    chk("t6_mem_en0", h_men[t+3], 0);
    chk("t6_mem_addr0", h_mad[t+3], 0);
    chk("t6_ls_rdata0", h_lsrd[t+3], 0);
    chk("t6_if_rdata0", h_ifrd[t+3], 0);
    chk("t6_fresh_gnt", h_lsg[t+3], 1);
    chk("t6_no_rvalid", h_lsrv[t+4], 0);

    // Random traffic; requesters hold their request until granted or dropped.
    for (int n = 0; n < 1500; n++) begin
      i_rst   = ($urandom_range(0, 199) == 0);
      i_flush = ($urandom_range(0, 7) == 0);
      if (i_if_req && !e_if_gnt) begin
        if ($urandom_range(0, 15) == 0) i_if_req = 0;
      end else begin
        i_if_req  = 1'($urandom_range(0, 1));
        i_if_addr = 32'($urandom_range(0, 255)) << 2;
      end
      if (i_ls_req && !e_ls_gnt) begin
        if ($urandom_range(0, 15) == 0) i_ls_req = 0;
      end else begin
        i_ls_req   = 1'($urandom_range(0, 1));
        i_ls_we    = 1'($urandom_range(0, 1));
        i_ls_addr  = 32'($urandom_range(0, 255)) << 2;
        i_ls_wdata = $urandom;
      end
      tick();
    end
    i_rst = 0; i_flush = 0; i_if_req = 0; i_ls_req = 0;
    repeat (8) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single-ported `main_memory` between two requesters: the instruction-fetch side (the `pc` stage) and the load/store side (the `mem_access` stage). Only one transaction is outstanding at a time. Load/store has priority, bounded by a fetch-starvation limit. A branch flush cancels an in-flight fetch result. The block sits between the pipeline stages and the memory, and its stall outputs feed `halt_control`.

## Interface

**Parameters**
- `XLEN`, 32: address and data width.
- `MEM_LAT`, 2: cycles from `o_mem_en` to valid `i_mem_rdata`. Legal range is at least 1.
- `STARVE_MAX`, 4: number of consecutive load/store grants a pending fetch may lose before it is forced to win.

**Ports**
- `i_clk`, in, 1: clock. The block uses this single clock.
- `i_rst`, in, 1: synchronous, active-high reset.
- `i_flush`, in, 1: taken-branch flush. Cancels any fetch result.
- `i_if_req`, in, 1: fetch request.
- `i_if_addr`, in, XLEN: fetch address.
- `o_if_gnt`, out, 1: fetch request accepted this cycle.
- `o_if_stall`, out, 1: equals `i_if_req & ~o_if_gnt`.
- `o_if_rvalid`, out, 1: one-cycle pulse when fetch data is valid.
- `o_if_rdata`, out, XLEN: fetched instruction.
- `i_ls_req`, in, 1: load/store request.
- `i_ls_we`, in, 1: 1 = store, 0 = load.
- `i_ls_addr`, in, XLEN: data address.
- `i_ls_wdata`, in, XLEN: store data.
- `o_ls_gnt`, out, 1: load/store request accepted this cycle.
- `o_ls_stall`, out, 1: equals `i_ls_req & ~o_ls_gnt`.
- `o_ls_rvalid`, out, 1: one-cycle completion pulse, for both loads and stores.
- `o_ls_rdata`, out, XLEN: load data. Updated only on load completion.
- `o_mem_en`, out, 1: memory access strobe.
- `o_mem_we`, out, 1: memory write enable.
- `o_mem_addr`, out, XLEN: memory address.
- `o_mem_wdata`, out, XLEN: memory write data.
- `i_mem_rdata`, in, XLEN: memory read data.

## Operation

**States**
- IDLE, BUSY_IF and BUSY_LS.
- A down-counter `lat_cnt` has width ceil(log2(MEM_LAT+2)) bits.

**IDLE**
- Grants are combinational, and at most one grant is asserted per cycle.
- The fetch side is eligible when `i_if_req & ~i_flush`.
- When both requests are present, load/store wins unless `starve_cnt == STARVE_MAX`, in which case fetch wins.
- On a grant:
  - Register the address, write enable and write data into the `o_mem_*` outputs. Fetch is always a read.
  - Pulse `o_mem_en` for one cycle.
  - Load `lat_cnt = MEM_LAT`.
  - Go to BUSY_IF or BUSY_LS.

**BUSY_x**
- Decrement `lat_cnt` each cycle.
- When `lat_cnt == 0`:
  - Capture `i_mem_rdata` into the x-side rdata register. For a store, the register is not written.
  - Assert `o_x_rvalid` in the next cycle, together with the return to IDLE.
- No grants are issued while busy.

**Starvation counter (`starve_cnt`)**
- Increments, saturating at STARVE_MAX, on each load/store grant that occurs while `i_if_req` is high.
- Clears on a fetch grant.
- Clears in any IDLE cycle in which `i_if_req` is low.

**Flush**
- `i_flush` in IDLE blocks the fetch grant for that cycle. A load/store grant may still occur.
- `i_flush` in BUSY_IF, or in the cycle the fetch `o_if_rvalid` would assert, sets the `drop` flag.
  - The memory access completes normally.
  - `o_if_rvalid` is suppressed.
  - `o_if_rdata` is still updated.
- `drop` clears on return to IDLE.
- `i_flush` has no effect on load/store.

**Requester rules**
- A requester holds its address and data stable while `req` is high and no grant has occurred.
- Values are sampled on the grant cycle.
- `req` may drop before grant with no side effect.
- After a grant, the requester must deassert or re-present `req`. A `req` still high in the `rvalid` cycle is treated as a new request.

**Reset**
- All outputs and registers reset to 0: `o_*_gnt`, `o_*_rvalid`, `o_*_rdata`, `o_mem_*`, `starve_cnt`, `lat_cnt`, `drop`. State resets to IDLE.
- While `i_rst` is high, grants are forced to 0.
- Reset asserted mid-transaction abandons the in-flight access. No `rvalid` is produced for it.

## Timing

Let T be the grant cycle.
- T: `o_x_gnt = 1`.
- T+1: `o_mem_en = 1` for one cycle, with `o_mem_addr/we/wdata` valid. State is BUSY.
- T+1+MEM_LAT: `i_mem_rdata` is sampled.
- T+2+MEM_LAT: `o_x_rvalid = 1` and state is IDLE. A new grant may occur in this same cycle.

Consequences:
- Throughput is one access per MEM_LAT+2 cycles.
- Minimum fetch latency from request to data is MEM_LAT+2 cycles.
- Stall outputs are combinational and have no register delay.

## Test plan

1. **Single fetch.** MEM_LAT=2, memory returns 0x00500093 for address 0x0. Drive `i_if_req=1` with `i_if_addr=0x0` at cycle 10.
   - Required: `o_if_gnt` at 10, `o_mem_en` at 11 with `o_mem_we=0`, `o_if_rvalid=1` and `o_if_rdata=0x00500093` at 14, `o_if_stall=0` at 10.
2. **Simultaneous fetch and load.** Both requests at cycle 10; `ls_addr=0x100` returns 0xDEADBEEF.
   - Required: `o_ls_gnt` at 10, `o_if_stall=1` for cycles 10–13, `o_ls_rdata=0xDEADBEEF` and `o_ls_rvalid` at 14, `o_if_gnt` at 14, `o_if_rvalid` at 18.
3. **Starvation limit.** STARVE_MAX=4. Hold `i_ls_req` and `i_if_req` high continuously.
   - Required: grant order is LS, LS, LS, LS, IF, then LS. `starve_cnt` reads 4 before the IF grant and 0 after it.
4. **Store.** Store of 0x12345678 to 0x200.
   - Required: `o_mem_we=1` and `o_mem_wdata=0x12345678` in the `o_mem_en` cycle, `o_ls_rvalid` pulses 3 cycles later, `o_ls_rdata` is unchanged from its prior value.
5. **Flush during fetch.** Fetch granted at 10; pulse `i_flush` at 12.
   - Required: no `o_if_rvalid` at 14, state IDLE at 14, next fetch grantable at 14.
   - Also: `i_flush` coincident with `i_if_req` in IDLE yields no `o_if_gnt` that cycle.
6. **Reset mid-transaction.** Load granted at 10; `i_rst=1` at 12 for one cycle.
   - Required: all outputs 0 at 13, no `o_ls_rvalid` at 14, a fresh request at 13 is granted at 13.
